// File: rtl/rle_enc.sv
// rle_enc: run-length encoder with pass-through mode and a 4-entry output FIFO
module rle_enc (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        arm,
  input  logic [1:0]  rle_mode,
  input  logic [3:0]  disabledGroups,
  input  logic [31:0] dataIn,
  input  logic        validIn,
  output logic [31:0] dataOut,
  output logic        validOut
);
  logic        r_have;
  logic [30:0] r_cur;
  logic [30:0] r_cnt;
  logic [31:0] r_q [4];
  logic [2:0]  r_qn;
  logic [31:0] w_pm;
  logic [31:0] w_flag;
  logic [30:0] w_max;
  logic [30:0] w_p;
  logic [30:0] w_inc;
  logic [31:0] w_cw;
  logic [1:0]  w_n;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic        w_have;
  logic [30:0] w_cur;
  logic [30:0] w_run;
  logic [2:0]  w_tot;
  logic [31:0] w_all [5];
  assign w_pm   = disabledGroups == 4'b1110 ? 32'h0000_007F :
                  disabledGroups == 4'b1100 ? 32'h0000_7FFF : 32'h7FFF_FFFF;
  assign w_flag = w_pm + 32'd1;
  assign w_max  = w_pm[30:0];
  assign w_p    = dataIn[30:0] & w_max;
  assign w_inc  = r_cnt + 31'd1;
  assign w_cw   = w_flag | {1'b0, r_cnt & w_max};
  // Word generation: up to two words per cycle (count then value, or flushed count then pass-through)
  always_comb begin
    w_n    = 2'd0;
    w_w0   = 32'd0;
    w_w1   = 32'd0;
    w_have = r_have;
    w_cur  = r_cur;
    w_run  = r_cnt;
    if (!enable) begin
      w_n    = {1'b0, r_cnt != 31'd0} + {1'b0, validIn};
      w_w0   = r_cnt != 31'd0 ? w_cw : dataIn;
      w_w1   = dataIn;
      w_have = 1'b0;
      w_run  = 31'd0;
    end else if (!arm) begin
      w_have = 1'b0;
      w_run  = 31'd0;
    end else if (validIn) begin
      if (!r_have || w_p != r_cur) begin
        w_n    = r_have && r_cnt != 31'd0 ? 2'd2 : 2'd1;
        w_w0   = r_have && r_cnt != 31'd0 ? w_cw : {1'b0, w_p};
        w_w1   = {1'b0, w_p};
        w_have = 1'b1;
        w_cur  = w_p;
        w_run  = 31'd0;
      end else if (w_inc >= w_max) begin
        w_n    = 2'd1;
        w_w0   = w_flag | {1'b0, w_max};
        w_have = rle_mode != 2'd0;
        w_run  = 31'd0;
      end else begin
        w_run  = w_inc;
      end
    end
  end
  assign w_tot = r_qn + {1'b0, w_n};
  genvar i;
  generate
    for (i = 0; i < 5; i++) begin : g_all
      if (i < 4) begin : g_q
        assign w_all[i] = 3'(i) < r_qn ? r_q[i] : 3'(i) == r_qn ? w_w0 : w_w1;
      end else begin : g_t
        assign w_all[i] = 3'(i) == r_qn ? w_w0 : w_w1;
      end
    end
  endgenerate
  // Output register takes the oldest queued word; the rest shift down in the FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      dataOut  <= 32'd0;
      validOut <= 1'b0;
      r_qn     <= 3'd0;
      r_have   <= 1'b0;
      r_cur    <= 31'd0;
      r_cnt    <= 31'd0;
      for (int k = 0; k < 4; k++) r_q[k] <= 32'd0;
    end else begin
      validOut <= w_tot != 3'd0;
      dataOut  <= w_tot != 3'd0 ? w_all[0] : 32'd0;
      r_qn     <= w_tot == 3'd0 ? 3'd0 : w_tot > 3'd5 ? 3'd4 : w_tot - 3'd1;
      r_have   <= w_have;
      r_cur    <= w_cur;
      r_cnt    <= w_run;
      for (int k = 0; k < 4; k++) r_q[k] <= w_all[k+1];
    end
  end
endmodule

// File: tb/tb_rle_enc.sv
// tb_rle_enc: scoreboard bench with directed vectors and a run-based reference model
module tb_rle_enc;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        arm = 1'b1;
  logic [1:0]  rle_mode = 2'd0;
  logic [3:0]  disabledGroups = 4'd0;
  logic [31:0] dataIn = 32'd0;
  logic        validIn = 1'b0;
  logic [31:0] dataOut;
  logic        validOut;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  rle_enc dut (
    .clock(clock), .reset(reset), .enable(enable), .arm(arm), .rle_mode(rle_mode),
    .disabledGroups(disabledGroups), .dataIn(dataIn), .validIn(validIn),
    .dataOut(dataOut), .validOut(validOut)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  always @(negedge clock) begin
    if (!reset && validOut) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", dataOut);
      end else begin
        chk("word", dataOut, exp_q.pop_front());
      end
    end
  end
  task automatic drive(input logic en, input logic v, input logic [31:0] d);
    enable = en;
    validIn = v;
    dataIn = d;
    @(posedge clock);
    #1;
  endtask
  task automatic pt(input logic v, input logic [31:0] d);
    if (v) exp_q.push_back(d);
    drive(1'b0, v, d);
  endtask
  function automatic int wsel(input logic [3:0] g);
    return g == 4'b1110 ? 8 : g == 4'b1100 ? 16 : 32;
  endfunction
  function automatic void model(input logic [31:0] pays [$], input int w, input int mode);
    longint mx = (longint'(1) << (w - 1)) - 1;
    logic [31:0] f = 32'(longint'(1) << (w - 1));
    longint i = 0;
    while (i < pays.size()) begin
      longint l = 1;
      while (i + l < pays.size() && pays[i+l] == pays[i]) l++;
      if (mode == 0) begin
        for (longint c = 0; c < l / (mx + 1); c++) begin
          exp_q.push_back(pays[i]);
          exp_q.push_back(f | 32'(mx));
        end
        if (l % (mx + 1) > 0) exp_q.push_back(pays[i]);
        if (l % (mx + 1) > 1) exp_q.push_back(f | 32'(l % (mx + 1) - 1));
      end else begin
        longint k = l - 1;
        exp_q.push_back(pays[i]);
        while (k >= mx) begin
          exp_q.push_back(f | 32'(mx));
          k -= mx;
        end
        if (k > 0) exp_q.push_back(f | 32'(k));
      end
      i += l;
    end
  endfunction
  task automatic setup(input logic [3:0] g, input logic [1:0] m);
    disabledGroups = g;
    rle_mode = m;
    drive(1'b0, 1'b0, 32'd0);
  endtask
  task automatic rand_seg();
    logic [3:0]  g;
    int          w;
    int          mode;
    logic [31:0] pm;
    logic [31:0] alph [3];
    logic [31:0] raw [$];
    logic        vv [$];
    logic [31:0] pays [$];
    int          sel = $urandom_range(0, 3);
    g = sel == 0 ? 4'b1110 : sel == 1 ? 4'b1100 : sel == 2 ? 4'b0000 : 4'($urandom);
    w = wsel(g);
    mode = $urandom_range(0, 3);
    pm = (32'd1 << (w - 1)) - 32'd1;
    for (int k = 0; k < 3; k++) alph[k] = $urandom & pm;
    for (int r = 0; r < int'($urandom_range(3, 10)); r++) begin
      logic [31:0] a = alph[$urandom_range(0, 2)];
      int len = ($urandom_range(0, 3) == 0 && w == 8) ? $urandom_range(120, 260) : $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          raw.push_back($urandom);
          vv.push_back(1'b0);
        end
        raw.push_back(($urandom & ~pm) | a);
        vv.push_back(1'b1);
        pays.push_back(a);
      end
    end
    setup(g, 2'(mode));
    model(pays, w, mode);
    for (int k = 0; k < raw.size(); k++) drive(1'b1, vv[k], raw[k]);
    for (int k = 0; k < int'($urandom_range(1, 4)); k++) pt(1'($urandom), $urandom);
  endtask
  task automatic enc_seq(input logic [31:0] s [$]);
    foreach (s[k]) drive(1'b1, 1'b1, s[k]);
    drive(1'b0, 1'b0, 32'd0);
  endtask
  initial begin
    repeat (3) drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("reset_validOut", {31'd0, validOut}, 32'd0);
    chk("reset_dataOut", dataOut, 32'd0);
    reset = 1'b0;
    pt(1'b1, 32'h4141_4141);
    chk("pt_lat_valid", {31'd0, validOut}, 32'd1);
    chk("pt_lat_data", dataOut, 32'h4141_4141);
    pt(1'b0, 32'h4141_4141);
    chk("pt_invalid", {31'd0, validOut}, 32'd0);
    setup(4'b1110, 2'd0);
    exp_q.push_back(32'h3B); exp_q.push_back(32'h44); exp_q.push_back(32'h81); exp_q.push_back(32'h3A);
    enc_seq('{32'hBB, 32'h44, 32'h44, 32'hBA});
    exp_q.push_back(32'h3B); exp_q.push_back(32'h44); exp_q.push_back(32'h82); exp_q.push_back(32'h3A);
    enc_seq('{32'hBB, 32'h44, 32'h44, 32'h44, 32'hBA});
    exp_q.push_back(32'h43); exp_q.push_back(32'h81); exp_q.push_back(32'h44);
    drive(1'b1, 1'b1, 32'h43);
    drive(1'b1, 1'b0, 32'h43);
    drive(1'b1, 1'b1, 32'h43);
    drive(1'b1, 1'b1, 32'h44);
    drive(1'b0, 1'b0, 32'd0);
    for (int m = 0; m < 2; m++) begin
      setup(4'b1110, 2'(m));
      exp_q.push_back(32'h4C); exp_q.push_back(32'hFF);
      exp_q.push_back(m == 0 ? 32'h4C : 32'h81); exp_q.push_back(32'h4D);
      repeat (129) drive(1'b1, 1'b1, 32'h4C);
      drive(1'b1, 1'b1, 32'h4D);
      drive(1'b0, 1'b0, 32'd0);
    end
    setup(4'b1100, 2'd0);
    exp_q.push_back(32'h4141); exp_q.push_back(32'h8003); exp_q.push_back(32'h4242);
    enc_seq('{32'h4141, 32'h4141, 32'h4141, 32'h4141, 32'h4242});
    setup(4'b0000, 2'd1);
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h8000_FFFF);
    repeat (65536) drive(1'b1, 1'b1, 32'h1234_5678);
    pt(1'b1, 32'hDEAD_BEEF);
    setup(4'b1110, 2'd0);
    arm = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 32'h11);
    arm = 1'b1;
    exp_q.push_back(32'h11);
    drive(1'b1, 1'b1, 32'h11);
    drive(1'b0, 1'b0, 32'd0);
    exp_q.push_back(32'h20);
    repeat (3) drive(1'b1, 1'b1, 32'h20);
    drive(1'b1, 1'b0, 32'd0);
    reset = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 32'd0);
    chk("midreset_validOut", {31'd0, validOut}, 32'd0);
    reset = 1'b0;
    pt(1'b1, 32'h55);
    repeat (3) drive(1'b0, 1'b0, 32'd0);
    repeat (20) rand_seg();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
